// File: rtl/serializer_lanes_if.sv
// Word-in / lane-out stream bundle for serializer_lanes.
// slave is the serializer side, master is the word producer plus beat consumer.
interface serializer_lanes_if #(
    parameter int DATA_WIDTH = 24,
    parameter int LANES      = 1
);
    logic [DATA_WIDTH-1:0] iv_din;
    logic                  i_din_valid;
    logic                  o_ready;
    logic [LANES-1:0]      ov_dout;
    logic                  o_dout_valid;
    logic                  i_ready;
    logic                  o_dout_last;

    modport slave (
        input  iv_din, i_din_valid, i_ready,
        output o_ready, ov_dout, o_dout_valid, o_dout_last
    );

    modport master (
        output iv_din, i_din_valid, i_ready,
        input  o_ready, ov_dout, o_dout_valid, o_dout_last
    );
endinterface

// File: rtl/serializer_lanes.sv
// Word-to-lane serializer with a one-word holding buffer for gapless streaming.
// Define SERIALIZER_PARITY_EN to append an even-parity beat after each word.
module serializer_lanes #(
    parameter int DATA_WIDTH = 24,
    parameter int LANES      = 1,
    parameter int MSB_FIRST  = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    serializer_lanes_if.slave  bus,
    output logic               o_busy
);
    localparam int BEATS = DATA_WIDTH / LANES;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    generate
        if ((DATA_WIDTH % LANES) != 0 || BEATS < 2) begin : g_param_check
            $error("serializer_lanes: DATA_WIDTH must be a multiple of LANES giving at least two beats");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
`ifdef SERIALIZER_PARITY_EN
        , ST_PARITY = 2'd2
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
`ifdef SERIALIZER_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic                  accept;
    logic                  consume;
    logic                  last_data;
    logic                  word_end;
    logic [DATA_WIDTH-1:0] shifted;

    assign bus.o_ready      = i_en & ~hold_full_q;
    assign bus.o_dout_valid = (state_q != ST_IDLE);
    assign o_busy           = (state_q != ST_IDLE) | hold_full_q;

    assign accept    = i_en & bus.i_din_valid & ~hold_full_q;
    assign consume   = i_en & bus.o_dout_valid & bus.i_ready;
    assign last_data = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
    assign shifted   = (MSB_FIRST != 0) ? (shift_q << LANES) : (shift_q >> LANES);

    // The shifter slot frees up when the final beat of a word (data or parity) leaves.
`ifdef SERIALIZER_PARITY_EN
    assign word_end        = consume && (state_q == ST_PARITY);
    assign bus.o_dout_last = (state_q == ST_PARITY);
`else
    assign word_end        = consume && last_data;
    assign bus.o_dout_last = last_data;
`endif

    always_comb begin
        bus.ov_dout = '0;
        if (state_q == ST_SHIFT) begin
            bus.ov_dout = (MSB_FIRST != 0) ? shift_q[DATA_WIDTH-1 -: LANES] : shift_q[LANES-1:0];
        end
`ifdef SERIALIZER_PARITY_EN
        else if (state_q == ST_PARITY) begin
            bus.ov_dout = LANES'(parity_q);
        end
`endif
    end

    // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
`ifdef SERIALIZER_PARITY_EN
        parity_d    = parity_q;
`endif

        if (consume && state_q == ST_SHIFT) begin
            shift_d = shifted;
            if (!last_data) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
`ifdef SERIALIZER_PARITY_EN
            else begin
                state_d = ST_PARITY;
            end
`endif
        end

        if (word_end || (state_q == ST_IDLE && accept)) begin
            cnt_d = '0;
            if (hold_full_q) begin
                shift_d     = hold_q;
                hold_full_d = 1'b0;
                state_d     = ST_SHIFT;
`ifdef SERIALIZER_PARITY_EN
                parity_d    = ^hold_q;
`endif
            end else if (accept) begin
                shift_d  = bus.iv_din;
                state_d  = ST_SHIFT;
`ifdef SERIALIZER_PARITY_EN
                parity_d = ^bus.iv_din;
`endif
            end else begin
                state_d = ST_IDLE;
            end
        end else if (accept) begin
            hold_d      = bus.iv_din;
            hold_full_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
`ifdef SERIALIZER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
`ifdef SERIALIZER_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end
endmodule

// File: tb/tb_serializer_lanes.sv
// Scoreboard bench: two serializers (LSB-first and MSB-first, 4 lanes) share one stimulus stream.
// Accepted words are expanded into expected beats; a monitor compares every presented beat.
module tb_serializer_lanes;
    localparam int DW = 24;
    localparam int LN = 4;
    localparam int BT = DW / LN;
`ifdef SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct packed {
        logic [LN-1:0] d;
        logic          last;
    } beat_t;

    logic i_clk = 1'b0;
    logic i_rst;
    logic i_en;
    logic o_busy0, o_busy1;

    serializer_lanes_if #(.DATA_WIDTH(DW), .LANES(LN)) bus0 ();
    serializer_lanes_if #(.DATA_WIDTH(DW), .LANES(LN)) bus1 ();

    assign bus1.iv_din      = bus0.iv_din;
    assign bus1.i_din_valid = bus0.i_din_valid;
    assign bus1.i_ready     = bus0.i_ready;

    serializer_lanes #(.DATA_WIDTH(DW), .LANES(LN), .MSB_FIRST(0)) u_dut_lsb (
        .i_clk (i_clk), .i_rst (i_rst), .i_en (i_en), .bus (bus0), .o_busy (o_busy0)
    );
    serializer_lanes #(.DATA_WIDTH(DW), .LANES(LN), .MSB_FIRST(1)) u_dut_msb (
        .i_clk (i_clk), .i_rst (i_rst), .i_en (i_en), .bus (bus1), .o_busy (o_busy1)
    );

    always #5 i_clk = ~i_clk;

    beat_t q_lsb[$];
    beat_t q_msb[$];
    int    words_in_flight = 0;
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word becomes BT lane chunks in the chosen order, plus a parity beat if enabled.
    function automatic void push_word(input logic [DW-1:0] w);
        logic [DW-1:0] t;
        for (int k = 0; k < BT; k++) begin
            t = w >> (k * LN);
            q_lsb.push_back('{d: t[LN-1:0], last: (k == BT - 1) && (PAR == 0)});
            t = w >> ((BT - 1 - k) * LN);
            q_msb.push_back('{d: t[LN-1:0], last: (k == BT - 1) && (PAR == 0)});
        end
        if (PAR != 0) begin
            q_lsb.push_back('{d: LN'(^w), last: 1'b1});
            q_msb.push_back('{d: LN'(^w), last: 1'b1});
        end
        words_in_flight++;
    endfunction

    // Monitor: compares status and beats at the falling edge, then retires consumed beats.
    initial begin
        logic          stalled;
        logic [LN-1:0] pd0, pd1;
        logic          pl0, pl1;
        logic          busy_exp;
        stalled = 1'b0;
        pd0 = '0; pd1 = '0; pl0 = 1'b0; pl1 = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                stalled = 1'b0;
            end else begin
                busy_exp = (q_lsb.size() != 0);
                check("valid_lsb", bus0.o_dout_valid, busy_exp);
                check("valid_msb", bus1.o_dout_valid, busy_exp);
                check("busy_lsb", o_busy0, busy_exp);
                check("busy_msb", o_busy1, busy_exp);
                check("ready_lsb", bus0.o_ready, i_en && (words_in_flight < 2));
                check("ready_msb", bus1.o_ready, i_en && (words_in_flight < 2));
                if (stalled) begin
                    check("stall_dout_lsb", bus0.ov_dout, pd0);
                    check("stall_last_lsb", bus0.o_dout_last, pl0);
                    check("stall_dout_msb", bus1.ov_dout, pd1);
                    check("stall_last_msb", bus1.o_dout_last, pl1);
                end
                if (q_lsb.size() != 0) begin
                    check("dout_lsb", bus0.ov_dout, q_lsb[0].d);
                    check("last_lsb", bus0.o_dout_last, q_lsb[0].last);
                    check("dout_msb", bus1.ov_dout, q_msb[0].d);
                    check("last_msb", bus1.o_dout_last, q_msb[0].last);
                end else begin
                    check("idle_dout_lsb", bus0.ov_dout, 0);
                    check("idle_last_lsb", bus0.o_dout_last, 0);
                    check("idle_dout_msb", bus1.ov_dout, 0);
                    check("idle_last_msb", bus1.o_dout_last, 0);
                end
                stalled = busy_exp && !(i_en && bus0.i_ready);
                pd0 = bus0.ov_dout; pl0 = bus0.o_dout_last;
                pd1 = bus1.ov_dout; pl1 = bus1.o_dout_last;
                if (busy_exp && i_en && bus0.i_ready) begin
                    if (q_lsb[0].last) words_in_flight--;
                    void'(q_lsb.pop_front());
                    void'(q_msb.pop_front());
                end
            end
        end
    end

    task automatic drive_cycle(input logic en, input logic vld, input logic [DW-1:0] din,
                               input logic rdy, output logic acc);
        @(posedge i_clk);
        #1;
        i_en             = en;
        bus0.i_din_valid = vld;
        bus0.iv_din      = din;
        bus0.i_ready     = rdy;
        @(negedge i_clk);
        #1;
        acc = en && vld && bus0.o_ready && !i_rst;
        if (acc) push_word(din);
    endtask

    task automatic run_seq(input logic [DW-1:0] words[$], input logic [3:0] pat, input int cycles);
        logic acc;
        int   idx = 0;
        for (int c = 0; c < cycles; c++) begin
            if (idx < words.size()) drive_cycle(1'b1, 1'b1, words[idx], pat[c % 4], acc);
            else                    drive_cycle(1'b1, 1'b0, '0, pat[c % 4], acc);
            if (acc) idx++;
        end
        check("seq_all_accepted", idx, words.size());
    endtask

    task automatic drain();
        logic acc;
        for (int c = 0; c < 200 && q_lsb.size() != 0; c++) begin
            drive_cycle(1'b1, 1'b0, '0, 1'b1, acc);
        end
        check("drain_empty", q_lsb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic           acc;
        logic           have_word;
        logic [DW-1:0]  word;
        logic           en_r, rdy_r;

        i_rst = 1'b1; i_en = 1'b0;
        bus0.i_din_valid = 1'b0; bus0.iv_din = '0; bus0.i_ready = 1'b1;
        #1;
        check("rst_valid", bus0.o_dout_valid, 0);
        check("rst_dout", bus0.ov_dout, 0);
        check("rst_last", bus0.o_dout_last, 0);
        check("rst_busy", o_busy0, 0);
        check("rst_ready_en_low", bus0.o_ready, 0);
        i_en = 1'b1;
        #1;
        check("rst_ready_en_high", bus0.o_ready, 1);
        @(posedge i_clk);
        #1 i_rst = 1'b0;

        // Back-to-back words with a free-running consumer, then with a 1,0,0,1 ready pattern.
        run_seq('{24'h123456, 24'hABCDEF}, 4'b1111, 20);
        drain();
        run_seq('{24'h123456, 24'hABCDEF}, 4'b1001, 40);
        drain();

        // New word offered exactly on the edge that consumes the last beat, hold empty.
        drive_cycle(1'b1, 1'b1, 24'h123456, 1'b1, acc);
        check("sc4_first_accept", acc, 1);
        for (int c = 0; c < BT - 1 + PAR; c++) drive_cycle(1'b1, 1'b0, '0, 1'b1, acc);
        drive_cycle(1'b1, 1'b1, 24'h000001, 1'b1, acc);
        check("sc4_second_accept", acc, 1);
        drain();
        run_seq('{24'h000003}, 4'b1111, 12);
        drain();

        // Asynchronous reset at beat 3 with a second word buffered.
        drive_cycle(1'b1, 1'b1, 24'h123456, 1'b1, acc);
        check("sc5_accept_a", acc, 1);
        drive_cycle(1'b1, 1'b1, 24'hABCDEF, 1'b1, acc);
        check("sc5_accept_b", acc, 1);
        drive_cycle(1'b1, 1'b0, '0, 1'b1, acc);
        drive_cycle(1'b1, 1'b0, '0, 1'b1, acc);
        check("sc5_busy_before", o_busy0, 1);
        #2;
        i_rst = 1'b1;
        q_lsb.delete();
        q_msb.delete();
        words_in_flight = 0;
        #1;
        check("sc5_valid_lsb", bus0.o_dout_valid, 0);
        check("sc5_valid_msb", bus1.o_dout_valid, 0);
        check("sc5_busy_lsb", o_busy0, 0);
        check("sc5_busy_msb", o_busy1, 0);
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        check("sc5_ready_after", bus0.o_ready, 1);
        for (int c = 0; c < 10; c++) drive_cycle(1'b1, 1'b0, '0, 1'b1, acc);

        // Randomised traffic: bursty producer, random enable and back-pressure.
        have_word = 1'b0;
        word = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!have_word && $urandom_range(0, 3) != 0) begin
                word = DW'($urandom);
                have_word = 1'b1;
            end
            en_r  = ($urandom_range(0, 7) != 0);
            rdy_r = ($urandom_range(0, 2) != 0);
            drive_cycle(en_r, have_word, word, rdy_r, acc);
            if (acc) have_word = 1'b0;
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
